// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// The EX stage holds start_i with stable operands. This block returns {HI, LO} = {remainder, quotient}
// and holds the result while start_i stays high.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam int              CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      DIV_FREE,
      DIV_BY_ZERO,
      DIV_ON,
      DIV_END
   } state_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   dvd_q;      // dividend magnitude, shifts out left while quotient bits shift in
   logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
   logic [WIDTH-1:0]   rem_q;      // partial remainder
   logic               sgn_q;      // latched signed_div_i
   logic               s1_q;       // dividend sign bit
   logic               s2_q;       // divisor sign bit
   logic [2*WIDTH-1:0] result_q;
   logic               ready_q;

   logic [WIDTH+1:0]   trial;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   dvd_d;
   logic [WIDTH-1:0]   op1_mag;
   logic [WIDTH-1:0]   op2_mag;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   // One restoring step plus operand magnitudes and final sign correction.
   always_comb begin
      // NOTE: every output gets a value on every path so no latch is inferred.
      trial = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
      rem_d = trial[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
      if (trial[WIDTH+1]) begin
         rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
         dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      end
      op1_mag  = (signed_div_i && opdata1_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
      op2_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;
      quot_fix = (sgn_q && (s1_q ^ s2_q)) ? ({WIDTH{1'b0}} - dvd_q) : dvd_q;
      rem_fix  = (sgn_q && s1_q) ? ({WIDTH{1'b0}} - rem_q) : rem_q;
   end

   // Control FSM and datapath registers, with registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (!rst) begin
         state_q  <= DIV_FREE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         sgn_q    <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         case (state_q)
            DIV_FREE: begin
               ready_q  <= 1'b0;
               result_q <= '0;
               if (start_i && !annul_i) begin
                  dvd_q   <= op1_mag;
                  dvs_q   <= op2_mag;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  sgn_q   <= signed_div_i;
                  s1_q    <= opdata1_i[WIDTH-1];
                  s2_q    <= opdata2_i[WIDTH-1];
                  state_q <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
               end
            end
            DIV_BY_ZERO: begin
               result_q <= '0;
               state_q  <= annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
               if (annul_i) begin
                  state_q  <= DIV_FREE;
                  ready_q  <= 1'b0;
                  result_q <= '0;
               end else if (cnt_q == LAST) begin
                  result_q <= {rem_fix, quot_fix};
                  ready_q  <= 1'b1;
                  state_q  <= DIV_END;
               end else begin
                  rem_q <= rem_d;
                  dvd_q <= dvd_d;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DIV_END: begin
               if (annul_i || !start_i) begin
                  state_q  <= DIV_FREE;
                  ready_q  <= 1'b0;
                  result_q <= '0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= DIV_FREE;
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit.
// Expected {remainder, quotient} and latency go into a scoreboard queue at launch.
// They are popped and compared when ready_o rises.
module tb_div_unit;

   localparam int W = 32;

   typedef struct {
      logic [2*W-1:0] res;
      int             lat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           signed_div = 1'b0;
   logic [W-1:0]   opdata1 = '0;
   logic [W-1:0]   opdata2 = '0;
   logic           start = 1'b0;
   logic           annul = 1'b0;
   logic [2*W-1:0] result;
   logic           ready;

   exp_t sb_q[$];
   int   tests_run = 0;
   int   fails     = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: {remainder, quotient}; truncating division, remainder takes the dividend's sign.
   function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb, q, r;
      if (b == '0) return '0;
      if (!sgn) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0000_0000, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
   endfunction

   // Drive a request; the caller is at a negedge. The next posedge is E0.
   task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      e.res = model(sgn, a, b);
      e.lat = (b == '0) ? 2 : W + 1;
      sb_q.push_back(e);
   endtask

   // Pass E0, scramble the operands, then wait (bounded) for ready_o.
   // Compare against the scoreboard, check hold, then release start.
   task automatic collect(input string tag);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = ~signed_div;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb_q.size() == 0) begin
         e.res = 'x;
         e.lat = -1;
      end else begin
         e = sb_q.pop_front();
      end
      check({tag, " latency"}, 64'(n), 64'(e.lat));
      check({tag, " result"}, result, e.res);
      @(posedge clk); #1;
      check({tag, " held result"}, result, e.res);
      check({tag, " held ready"}, 64'(ready), 64'd1);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, " release ready"}, 64'(ready), 64'd0);
      check({tag, " release result"}, result, 64'd0);
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      launch(sgn, a, b);
      collect(tag);
   endtask

   // Count ready_o highs over a window with start_i low; it should stay idle.
   task automatic idle_window(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ready === 1'b1) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   // Directed sequence.
   initial begin
      int n;
      #1;
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_div("u100/7", 1'b0, 32'd100, 32'd7);
      run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
      run_div("s7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
      run_div("s5/0", 1'b1, 32'd5, 32'd0);
      run_div("u5/0", 1'b0, 32'd5, 32'd0);
      run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("uFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      run_div("u_big", 1'b0, 32'hDEAD_BEEF, 32'h0001_2345);
      run_div("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

      // start with annul in DIV_FREE must not launch; E0 is the edge after annul drops.
      @(negedge clk);
      annul = 1'b1;
      launch(1'b0, 32'd50, 32'd5);
      repeat (3) @(posedge clk);
      #1;
      check("start+annul idle", 64'(ready), 64'd0);
      @(negedge clk);
      annul = 1'b0;
      collect("u50/5 after annul");

      // Annul at counter=10: the division is dropped and ready never rises.
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd1000;
      opdata2    = 32'd7;
      start      = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      @(posedge clk); #1;
      check("annul ready", 64'(ready), 64'd0);
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      idle_window("annul no ready");
      run_div("u9/3", 1'b0, 32'd9, 32'd3);

      // Asynchronous reset between edges at counter=20.
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd1000;
      opdata2    = 32'd3;
      start      = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async rst ready", 64'(ready), 64'd0);
      check("async rst result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle_window("rst no ready");
      run_div("u1000/10", 1'b0, 32'd1000, 32'd10);

      // Asynchronous reset while a nonzero result is being held.
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd12;
      opdata2    = 32'd5;
      start      = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("pre-rst result", result, {32'd2, 32'd2});
      #2;
      rst = 1'b0;
      #1;
      check("rst in END ready", 64'(ready), 64'd0);
      check("rst in END result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_div("s-1000/10", 1'b1, 32'hFFFF_FC18, 32'd10);

      check("scoreboard empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving as the responder to the EX stage's divide request (DIV/DIVU).
- EX acts as the initiator: it raises start_i with both operands and holds them, then consumes result_o as {HI, LO} on its hi_o/lo_o/whilo_o path once ready_o asserts.
- Algorithm is radix-2 restoring division, one quotient bit per cycle.
- The pipeline stall decision stays in EX/ctrl; this block only computes and handshakes.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH and the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
- signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  WIDTH  dividend; held stable by EX while start_i=1
- opdata2_i  input  WIDTH  divisor; held stable by EX while start_i=1
- start_i  input  1  division request; level, held until result consumed
- annul_i  input  1  cancel in-flight/pending division (branch-delay flush or exception)
- result_o  output  2*WIDTH  {remainder (HI), quotient (LO)}
- ready_o  output  1  result_o valid

Behaviour:
- Reset (rst=0, asynchronous):
  - state=DIV_FREE, ready_o=0, result_o=0, iteration counter=0, working registers=0.
  - Takes effect immediately, including mid-division; no partial result survives.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- DIV_FREE:
  - On an edge with start_i=1 and annul_i=0:
    - opdata2_i==0: go to DIV_BY_ZERO.
    - Otherwise: go to DIV_ON, counter=0.
    - Load the dividend magnitude and divisor magnitude. When signed_div_i=1 and an operand's MSB is 1, load its two's complement; otherwise load it unchanged.
  - Latch signed_div_i and both operand sign bits for the final correction.
  - ready_o=0, result_o=0.
- DIV_BY_ZERO: next edge go to DIV_END with quotient=0 and remainder=0.
- DIV_ON, while counter<WIDTH:
  - Form the (WIDTH+1)-bit trial difference {partial_rem, next dividend bit} - divisor.
  - Non-negative: keep the difference and shift in quotient bit 1.
  - Negative: keep the shifted partial remainder and shift in 0.
  - counter increments.
- DIV_ON, counter==WIDTH: apply sign fixup, register result_o, set ready_o=1, go to DIV_END.
- DIV_ON, annul_i=1 on any edge: go to DIV_FREE, ready_o=0, result discarded. Annul has priority over iteration and completion.
- Sign fixup (signed only):
  - Quotient negated if dividend sign XOR divisor sign.
  - Remainder negated if dividend sign=1.
  - Unsigned results are used unchanged.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. No trap; the result wraps.
- DIV_END:
  - ready_o=1 and result_o held stable while start_i=1.
  - On an edge with start_i=0: go to DIV_FREE, ready_o=0, result_o=0.
  - annul_i=1 in DIV_END: go to DIV_FREE, ready_o=0, result_o=0.
- Latency, with E0 = the edge that samples start_i in DIV_FREE:
  - Nonzero divisor: ready_o rises after edge E0+WIDTH+1 (E0+33 for WIDTH=32).
  - Divisor zero: ready_o rises after E0+2.
- A new division requires start_i to fall, returning the block to DIV_FREE. start_i held high across two divides is not a back-to-back request.
- Operands are sampled only at E0. Changes during DIV_ON are ignored.
- start_i=1 with annul_i=1 in DIV_FREE: no transition.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held -> ready_o rises exactly 33 cycles after E0, result_o={0x00000002, 0x0000000E}. Then drop start -> ready_o=0 and result_o=0 on the next edge.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 5/0 -> ready_o after E0+2, result_o=0. Repeat in both signed and unsigned modes.
- Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/0x00000001 -> {0x00000000, 0xFFFFFFFF}.
- Pulse annul_i at counter=10 -> DIV_FREE and ready_o never asserts. Then start 9/3 -> {0, 3} at full latency.
- Drive rst=0 asynchronously (between edges) at counter=20 -> ready_o=0 and result_o=0 immediately. After release, start 1000/10 -> {0, 100} with normal latency.
